spi_slave_v1_0: RTL and testbench
=================================

SPI_SLAVE_V1_0 -- requirements
Module: spi_slave_v1_0

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning frame length in bits (range 2..32).
REQ-002 SHALL have parameter CPOL, default 1'b0, meaning the idle level of spi_clk.
REQ-003 SHALL have parameter CPHA, default 1'b0, meaning 0 = sample on the leading edge, 1 = sample on the trailing edge.
REQ-004 SHALL have port i_clk, input, 1, the only system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port spi_clk, input, 1, SPI clock from the master, asynchronous to i_clk.
REQ-007 SHALL have port n_cs, input, 1, active-low chip select from the master.
REQ-008 SHALL have port mosi, input, 1, serial data from the master.
REQ-009 SHALL have port miso, output, 1, serial data to the master, 1'bz while n_cs is high.
REQ-010 SHALL have port i_miso_data, input, DATA_WIDTH, the word to transmit, captured at frame start.
REQ-011 SHALL have port o_mosi_data, output reg, DATA_WIDTH, the last complete received word.
REQ-012 SHALL have port o_valid, output, 1, a one-cycle pulse when o_mosi_data updates.
REQ-013 SHALL have port o_busy, output, 1, high while a frame is in progress.
REQ-014 SHALL have port o_spi_state, output, 2, the FSM state for debug.

Function
REQ-015 SHALL pass spi_clk, n_cs and mosi through 2-flop synchronizers, then detect edges by comparing against a third registered stage.
- Leading edge = spi_clk leaving the CPOL level; trailing edge = spi_clk returning to the CPOL level.
REQ-016 SHALL implement FSM states idle(0) -> load(1) -> active(2) -> done(3) -> idle.
REQ-017 In idle, SHALL move to load on a synchronized n_cs falling edge.
REQ-018 In load (one cycle), SHALL capture i_miso_data into the TX shift register, clear the bit counter, then enter active.
REQ-019 In active, on each sample edge, SHALL shift synchronized mosi into the RX register LSB and increment the bit counter.
REQ-020 SHALL drive miso from TX register bit [DATA_WIDTH-1].
- CPHA=0: shift TX on each trailing edge.
- CPHA=1: shift TX on each leading edge except the first of the frame.
REQ-021 When the bit counter reaches DATA_WIDTH, SHALL register RX into o_mosi_data and pulse o_valid, then enter done.
- This happens in the cycle after the edge strobe.
- Latency from the pin edge to o_valid high is 4 i_clk cycles.
REQ-022 In done, SHALL ignore further spi_clk edges and hold miso at 0 (low) until n_cs rises.
REQ-023 On a synchronized n_cs rise, SHALL return to idle from any state, with no o_valid unless the frame completed.
- A mid-frame abort discards the partial word; o_mosi_data holds its previous value.
REQ-024 If an n_cs fall and a spi_clk edge arrive in the same synchronized cycle, SHALL ignore that edge.
REQ-025 SHALL drive o_busy high in load, active and done states.
REQ-026 SHALL operate correctly only when each spi_clk half-period is at least 4 i_clk cycles.
- The master's MISO sampling margin must cover 4 i_clk cycles of output delay.

Reset
REQ-027 On i_rst low, SHALL asynchronously force state to idle and clear all counters and shift registers.
- o_mosi_data = 0, o_valid = 0, o_busy = 0, o_spi_state = 0.
- Synchronizer flops reset to n_cs = 1 and spi_clk = CPOL.
REQ-028 On reset release with n_cs already low, SHALL not start a frame until a fresh n_cs fall.

Configuration
REQ-029 With macro SPI_SLAVE_FRAME_ERR_EN defined, SHALL add output o_frame_err (1 bit, reset 0).
- o_frame_err pulses one cycle when n_cs rises with bit count other than 0 or DATA_WIDTH.
- o_frame_err also pulses when a sample edge arrives in the done state.
REQ-030 Without SPI_SLAVE_FRAME_ERR_EN, the port and its logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-031 SHALL take FSM state encodings (idle/load/active/done) and the synchronizer depth constant (2) from shared package spi_pkg.
REQ-032 SHALL instantiate sub-module spi_sync_edge (parameterized 2-flop synchronizer with rise/fall strobes) once per input: spi_clk, n_cs, mosi.

Verification
REQ-033 The bench SHALL cover CPOL=0/CPHA=0, DATA_WIDTH=16, i_clk:spi half-period 1:4.
- Master sends 0xA5C3 while i_miso_data = 0x3C5A.
- Required: o_mosi_data = 0xA5C3 with one o_valid pulse; the master receives 0x3C5A.
REQ-034 The bench SHALL repeat REQ-033 for modes (0,1), (1,0) and (1,1).
- Required: identical data results in all modes.
REQ-035 The bench SHALL cover an abort: n_cs rises after 7 bits.
- Required: no o_valid, o_mosi_data unchanged, state returns to idle within 4 cycles.
- With SPI_SLAVE_FRAME_ERR_EN: exactly one o_frame_err pulse.
REQ-036 The bench SHALL cover an overlong frame of 18 clocks.
- Required: o_mosi_data = the first 16 bits, one o_valid pulse, miso = 0 on bits 17-18.
REQ-037 The bench SHALL cover two back-to-back frames 0x0001 then 0xFFFF, with n_cs high for 4 i_clk cycles between them.
- Required: two o_valid pulses with the correct words.
- i_miso_data changed between frames is captured anew.
REQ-038 The bench SHALL assert i_rst mid-frame.
- Required: all outputs at reset values immediately, and no frame on release while n_cs is low.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and synchronizer depth shared by the SPI slave files.
package spi_pkg;
   localparam int SYNC_DEPTH = 2;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_DONE   = 2'd3
   } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer plus one extra stage for rise/fall strobes.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int DEPTH   = SYNC_DEPTH,
   parameter bit RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic [DEPTH:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[DEPTH-1:0], i_async};
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) sync_q <= {(DEPTH + 1){RST_VAL}};
      else        sync_q <= sync_d;
   end
   assign o_level = sync_q[DEPTH-1];
   assign o_rise  = sync_q[DEPTH-1] & ~sync_q[DEPTH];
   assign o_fall  = ~sync_q[DEPTH-1] & sync_q[DEPTH];
endmodule

// File: rtl/spi_slave_v1_0.sv
// spi_slave_v1_0: SPI slave oversampled in the i_clk domain, CPOL/CPHA configurable.
// Define SPI_SLAVE_FRAME_ERR_EN to add the o_frame_err pulse output.
module spi_slave_v1_0
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  spi_clk,
   input  logic                  n_cs,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] i_miso_data,
   output logic [DATA_WIDTH-1:0] o_mosi_data,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic [1:0]            o_spi_state
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,
   output logic                  o_frame_err
`endif
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
   spi_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, data_q, data_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [1:0]            settle_q, settle_d;
   logic                  valid_q, valid_d, armed_q, armed_d;
   logic                  sclk_rise, sclk_fall, sclk_lvl_unused;
   logic                  ncs_lvl, ncs_rise, ncs_fall;
   logic                  mosi_lvl, mosi_rise_unused, mosi_fall_unused;
   logic                  lead, trail, sample, shift;

   spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
      .i_clk(i_clk), .i_rst(i_rst), .i_async(spi_clk),
      .o_level(sclk_lvl_unused), .o_rise(sclk_rise), .o_fall(sclk_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
      .i_clk(i_clk), .i_rst(i_rst), .i_async(n_cs),
      .o_level(ncs_lvl), .o_rise(ncs_rise), .o_fall(ncs_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
      .i_clk(i_clk), .i_rst(i_rst), .i_async(mosi),
      .o_level(mosi_lvl), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
   );

   assign lead   = CPOL ? sclk_fall : sclk_rise;
   assign trail  = CPOL ? sclk_rise : sclk_fall;
   assign sample = CPHA ? trail : lead;
   // With CPHA=1 the MSB is already on miso, so the first leading edge must not shift.
   assign shift  = CPHA ? (lead && cnt_q != '0) : trail;

   // The synchronizer resets to n_cs high, so a fall seen before the pipeline has
   // flushed and observed a genuine high level is a reset artefact, not a frame start.
   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      cnt_d    = cnt_q;
      settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      armed_d  = armed_q | (settle_q == 2'd3 && ncs_lvl);
      valid_d  = state_q == ST_ACTIVE && cnt_q == FULL;
      data_d   = valid_d ? rx_q : data_q;
      case (state_q)
         ST_IDLE: state_d = (ncs_fall && armed_q) ? ST_LOAD : ST_IDLE;
         ST_LOAD: begin
            tx_d    = i_miso_data;
            rx_d    = '0;
            cnt_d   = '0;
            state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (cnt_q == FULL) state_d = ST_DONE;
            else begin
               rx_d  = sample ? {rx_q[DATA_WIDTH-2:0], mosi_lvl} : rx_q;
               cnt_d = sample ? cnt_q + 1'b1 : cnt_q;
               tx_d  = shift ? {tx_q[DATA_WIDTH-2:0], 1'b0} : tx_q;
            end
         end
         default: state_d = ST_DONE;
      endcase
      if (ncs_rise) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= ST_IDLE;
         tx_q     <= '0;
         rx_q     <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         settle_q <= '0;
         valid_q  <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         valid_q  <= valid_d;
         armed_q  <= armed_d;
      end
   end

`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic err_q, err_d;
   always_comb err_d = (ncs_rise && cnt_q != '0 && cnt_q != FULL) || (state_q == ST_DONE && sample);
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   assign o_frame_err = err_q;
`endif

   assign miso        = n_cs ? 1'bz : (state_q == ST_DONE ? 1'b0 : tx_q[DATA_WIDTH-1]);
   assign o_mosi_data = data_q;
   assign o_valid     = valid_q;
   assign o_busy      = state_q != ST_IDLE;
   assign o_spi_state = state_q;
endmodule

// File: tb/tb_spi_slave_v1_0.sv
// tb_spi_slave_v1_0: directed bench, one DUT per SPI mode (index = {CPOL,CPHA}).
module tb_spi_slave_v1_0;
   localparam int H = 4;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [3:0]  spi_clk = 4'b1100;
   logic [3:0]  n_cs = 4'hF;
   logic [3:0]  mosi = 4'h0;
   wire  [3:0]  miso, valid, busy;
   logic [15:0] miso_data [4];
   wire  [15:0] mosi_data [4];
   wire  [1:0]  st [4];
   int          vcnt [4];
   int          checks = 0;
   int          errors = 0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   wire  [3:0]  ferr;
   int          ecnt [4];
`endif

   always #5 i_clk = ~i_clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_v1_0 #(
         .DATA_WIDTH(16),
         .CPOL(g >= 2 ? 1'b1 : 1'b0),
         .CPHA(g % 2 == 1 ? 1'b1 : 1'b0)
      ) u_dut (
         .i_clk(i_clk), .i_rst(i_rst), .spi_clk(spi_clk[g]), .n_cs(n_cs[g]),
         .mosi(mosi[g]), .miso(miso[g]), .i_miso_data(miso_data[g]),
         .o_mosi_data(mosi_data[g]), .o_valid(valid[g]), .o_busy(busy[g]),
         .o_spi_state(st[g])
`ifdef SPI_SLAVE_FRAME_ERR_EN
         , .o_frame_err(ferr[g])
`endif
      );
   end

   always @(negedge i_clk) begin
      for (int k = 0; k < 4; k++) begin
         if (valid[k] === 1'b1) vcnt[k] <= vcnt[k] + 1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         if (ferr[k] === 1'b1) ecnt[k] <= ecnt[k] + 1;
`endif
      end
   end

   // Master: drops n_cs (if not already low), waits, then clocks nbits MSB first.
   task automatic xfer(input int m, input int nbits, input logic [31:0] tx, output logic [31:0] rx);
      logic cpol, cpha;
      cpol = m >= 2;
      cpha = m % 2 == 1;
      rx = '0;
      n_cs[m] = 1'b0;
      mosi[m] = tx[nbits-1];
      repeat (2 * H) @(negedge i_clk);
      for (int i = 0; i < nbits; i++) begin
         if (cpha) mosi[m] = tx[nbits-1-i];
         if (!cpha) rx = {rx[30:0], miso[m]};
         spi_clk[m] = ~cpol;
         repeat (H) @(negedge i_clk);
         if (cpha) rx = {rx[30:0], miso[m]};
         spi_clk[m] = cpol;
         if (!cpha) mosi[m] = (i + 1 < nbits) ? tx[nbits-2-i] : 1'b0;
         repeat (H) @(negedge i_clk);
      end
      repeat (2) @(negedge i_clk);
   endtask

   task automatic end_frame(input int m);
      n_cs[m] = 1'b1;
      mosi[m] = 1'b0;
      repeat (H) @(negedge i_clk);
   endtask

   task automatic test_reset;
      for (int m = 0; m < 4; m++) begin
         checks += 4;
         if (mosi_data[m] !== 16'h0) begin errors++; $display("FAIL reset_data[%0d]: got %h expected 0000", m, mosi_data[m]); end
         if (valid[m] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", m, valid[m]); end
         if (busy[m] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", m, busy[m]); end
         if (st[m] !== 2'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d expected 0", m, st[m]); end
      end
   endtask

   task automatic test_modes;
      logic [31:0] rx;
      int v0;
      for (int m = 0; m < 4; m++) begin
         miso_data[m] = 16'h3C5A;
         v0 = vcnt[m];
         xfer(m, 16, 32'hA5C3, rx);
         checks += 2;
         if (st[m] !== 2'd3) begin errors++; $display("FAIL mode%0d_done_state: got %0d expected 3", m, st[m]); end
         if (miso[m] !== 1'b0) begin errors++; $display("FAIL mode%0d_done_miso: got %b expected 0", m, miso[m]); end
         end_frame(m);
         checks += 5;
         if (mosi_data[m] !== 16'hA5C3) begin errors++; $display("FAIL mode%0d_rx_word: got %h expected a5c3", m, mosi_data[m]); end
         if (vcnt[m] - v0 !== 1) begin errors++; $display("FAIL mode%0d_valid_pulses: got %0d expected 1", m, vcnt[m] - v0); end
         if (rx[15:0] !== 16'h3C5A) begin errors++; $display("FAIL mode%0d_master_rx: got %h expected 3c5a", m, rx[15:0]); end
         if (st[m] !== 2'd0) begin errors++; $display("FAIL mode%0d_idle_state: got %0d expected 0", m, st[m]); end
         if (busy[m] !== 1'b0) begin errors++; $display("FAIL mode%0d_idle_busy: got %b expected 0", m, busy[m]); end
      end
   endtask

   task automatic test_abort;
      logic [31:0] rx;
      int v0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      int e0;
      e0 = ecnt[0];
`endif
      v0 = vcnt[0];
      xfer(0, 7, 32'h55, rx);
      checks += 1;
      if (busy[0] !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b expected 1", busy[0]); end
      end_frame(0);
      checks += 3;
      if (st[0] !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", st[0]); end
      if (vcnt[0] !== v0) begin errors++; $display("FAIL abort_valid: got %0d pulses expected 0", vcnt[0] - v0); end
      if (mosi_data[0] !== 16'hA5C3) begin errors++; $display("FAIL abort_data_held: got %h expected a5c3", mosi_data[0]); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      repeat (2) @(negedge i_clk);
      checks += 1;
      if (ecnt[0] - e0 !== 1) begin errors++; $display("FAIL abort_frame_err: got %0d expected 1", ecnt[0] - e0); end
`endif
   endtask

   task automatic test_overlong;
      logic [31:0] rx;
      int v0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      int e0;
      e0 = ecnt[0];
`endif
      v0 = vcnt[0];
      miso_data[0] = 16'h3C5A;
      xfer(0, 18, 32'h2970F, rx);
      end_frame(0);
      checks += 4;
      if (mosi_data[0] !== 16'hA5C3) begin errors++; $display("FAIL overlong_word: got %h expected a5c3", mosi_data[0]); end
      if (vcnt[0] - v0 !== 1) begin errors++; $display("FAIL overlong_valid: got %0d expected 1", vcnt[0] - v0); end
      if (rx[17:2] !== 16'h3C5A) begin errors++; $display("FAIL overlong_master_rx: got %h expected 3c5a", rx[17:2]); end
      if (rx[1:0] !== 2'b00) begin errors++; $display("FAIL overlong_tail_miso: got %b expected 00", rx[1:0]); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      checks += 1;
      if (ecnt[0] - e0 !== 2) begin errors++; $display("FAIL overlong_frame_err: got %0d expected 2", ecnt[0] - e0); end
`endif
   endtask

   task automatic test_back_to_back;
      logic [31:0] rx;
      int v0;
      v0 = vcnt[0];
      miso_data[0] = 16'h1234;
      xfer(0, 16, 32'h0001, rx);
      n_cs[0] = 1'b1;
      miso_data[0] = 16'hBEEF;
      repeat (H) @(negedge i_clk);
      checks += 2;
      if (mosi_data[0] !== 16'h0001) begin errors++; $display("FAIL b2b_word1: got %h expected 0001", mosi_data[0]); end
      if (rx[15:0] !== 16'h1234) begin errors++; $display("FAIL b2b_master_rx1: got %h expected 1234", rx[15:0]); end
      xfer(0, 16, 32'hFFFF, rx);
      end_frame(0);
      checks += 3;
      if (mosi_data[0] !== 16'hFFFF) begin errors++; $display("FAIL b2b_word2: got %h expected ffff", mosi_data[0]); end
      if (rx[15:0] !== 16'hBEEF) begin errors++; $display("FAIL b2b_master_rx2: got %h expected beef", rx[15:0]); end
      if (vcnt[0] - v0 !== 2) begin errors++; $display("FAIL b2b_valid: got %0d expected 2", vcnt[0] - v0); end
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] rx;
      int v0;
      miso_data[0] = 16'h3C5A;
      xfer(0, 5, 32'h15, rx);
      i_rst = 1'b0;
      #1;
      checks += 4;
      if (mosi_data[0] !== 16'h0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0000", mosi_data[0]); end
      if (valid[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", valid[0]); end
      if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy[0]); end
      if (st[0] !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", st[0]); end
      @(negedge i_clk);
      i_rst = 1'b1;
      v0 = vcnt[0];
      xfer(0, 16, 32'hFFFF, rx);
      checks += 3;
      if (st[0] !== 2'd0) begin errors++; $display("FAIL rst_release_state: got %0d expected 0", st[0]); end
      if (vcnt[0] !== v0) begin errors++; $display("FAIL rst_release_valid: got %0d pulses expected 0", vcnt[0] - v0); end
      if (mosi_data[0] !== 16'h0) begin errors++; $display("FAIL rst_release_data: got %h expected 0000", mosi_data[0]); end
      end_frame(0);
      xfer(0, 16, 32'hA5C3, rx);
      end_frame(0);
      checks += 2;
      if (mosi_data[0] !== 16'hA5C3) begin errors++; $display("FAIL rst_recover_word: got %h expected a5c3", mosi_data[0]); end
      if (rx[15:0] !== 16'h3C5A) begin errors++; $display("FAIL rst_recover_master_rx: got %h expected 3c5a", rx[15:0]); end
   endtask

   initial begin
      for (int m = 0; m < 4; m++) miso_data[m] = 16'h0;
      repeat (3) @(negedge i_clk);
      test_reset;
      i_rst = 1'b1;
      repeat (8) @(negedge i_clk);
      test_modes;
      test_abort;
      test_overlong;
      test_back_to_back;
      test_reset_mid_frame;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
